// File: rtl/div_pkg.sv
// Shared types for the repeated-subtraction divider: FSM states, datapath
// control strobes and the default operand width.
package div_pkg;

    localparam int DIV_WIDTH = 16;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD_D = 2'd1,
        S_ITER   = 2'd2,
        S_DONE   = 2'd3
    } div_state_t;

    // One strobe per datapath action; at most one is high in any cycle.
    typedef struct packed {
        logic load_r;
        logic load_d;
        logic step;
        logic q_fill;
    } dp_ctrl_t;

endpackage

// File: rtl/repsub_divider_if.sv
// Request/result bundle of the divider: operand bus in, status and result out.
interface repsub_divider_if import div_pkg::*; #(
    parameter int WIDTH = DIV_WIDTH
) ();

    // start is a one-cycle request, accepted only while the divider is idle
    // or done; it is never queued. data_in carries the dividend with start and
    // the divisor in the following cycle. done stays high with a stable
    // quotient/remainder/div_by_zero until the next accepted start or reset.
    logic             start;
    logic [WIDTH-1:0] data_in;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (
        output start, data_in,
        input  busy, done, div_by_zero, quotient, remainder
    );

    modport slave (
        input  start, data_in,
        output busy, done, div_by_zero, quotient, remainder
    );

endinterface

// File: rtl/repsub_div_datapath.sv
// Remainder/divisor/quotient registers with the subtractor, >= comparator
// and divisor zero detect, stepped by strobes from the divider FSM.
module repsub_div_datapath import div_pkg::*; #(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  dp_ctrl_t         ctrl,
    input  logic [WIDTH-1:0] data_in,
    output logic             r_ge_d,
    output logic             d_is_zero,
    output logic [WIDTH-1:0] r_out,
    output logic [WIDTH-1:0] q_out
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] diff;

    // The FSM only steps when r_ge_d, so diff never wraps when it is used.
    assign diff      = r_q - d_q;
    assign r_ge_d    = (r_q >= d_q);
    assign d_is_zero = (d_q == '0);

    always_comb begin
        r_d = r_q;
        d_d = d_q;
        q_d = q_q;
        if (ctrl.load_r) begin
            r_d = data_in;
            q_d = '0;
        end
        if (ctrl.load_d) begin
            d_d = data_in;
        end
        if (ctrl.step) begin
            r_d = diff;
            q_d = q_q + ONE;
        end
        if (ctrl.q_fill) begin
            q_d = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
            d_q <= '0;
            q_q <= '0;
        end else begin
            r_q <= r_d;
            d_q <= d_d;
            q_q <= q_d;
        end
    end

    assign r_out = r_q;
    assign q_out = q_q;

endmodule

// File: rtl/repsub_divider.sv
// Unsigned repeated-subtraction divider: FSM sequencing operand capture and
// one subtract per cycle, with a start/done handshake on the interface.
module repsub_divider import div_pkg::*; #(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    repsub_divider_if.slave  bus,
    output div_state_t       dbg_state
);

    div_state_t       state_q, state_d;
    logic             dbz_q, dbz_d;
    dp_ctrl_t         ctrl;
    logic             r_ge_d;
    logic             d_is_zero;
    logic [WIDTH-1:0] r_val;
    logic [WIDTH-1:0] q_val;

    repsub_div_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk       (clk),
        .rst       (rst),
        .ctrl      (ctrl),
        .data_in   (bus.data_in),
        .r_ge_d    (r_ge_d),
        .d_is_zero (d_is_zero),
        .r_out     (r_val),
        .q_out     (q_val)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dbz_d   = dbz_q;
        ctrl    = '0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    ctrl.load_r = 1'b1;
                    dbz_d       = 1'b0;
                    state_d     = S_LOAD_D;
                end
            end
            S_LOAD_D: begin
                ctrl.load_d = 1'b1;
                state_d     = S_ITER;
            end
            S_ITER: begin
                // Zero divisor short-circuits: remainder keeps the dividend.
                if (d_is_zero) begin
                    ctrl.q_fill = 1'b1;
                    dbz_d       = 1'b1;
                    state_d     = S_DONE;
                end else if (r_ge_d) begin
                    ctrl.step = 1'b1;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.busy        = (state_q == S_LOAD_D) || (state_q == S_ITER);
    assign bus.done        = (state_q == S_DONE);
    assign bus.div_by_zero = dbz_q;
    assign bus.quotient    = q_val;
    assign bus.remainder   = r_val;
    assign dbg_state       = state_q;

endmodule
